// File: rtl/pll_lock_supervisor_pkg.sv
// +----------------------------------------------------------------------------+
// | pll_lock_supervisor_pkg : state encoding and default timing constants      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET    = 3'd0,
    ST_WAIT_LOCK    = 3'd1,
    ST_STABLE_CHECK = 3'd2,
    ST_RST_HOLD     = 3'd3,
    ST_RUN          = 3'd4
  } state_e;

  localparam int unsigned C_PLL_RST_CYCLES     = 16;
  localparam int unsigned C_LOCK_TIMEOUT       = 50000;
  localparam int unsigned C_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned C_SYS_RST_HOLD       = 64;

  localparam logic [7:0] C_RELOCK_MAX = 8'hFF;

  function automatic int unsigned max4(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c,
                                       input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width of a down-counter that must be loadable with maxval.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +----------------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for a single asynchronous level           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// +----------------------------------------------------------------------------+
// | pll_lock_supervisor : PLL reset sequencing, lock qualification, sys reset  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = C_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = C_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE_CYCLES = C_LOCK_STABLE_CYCLES,
  parameter int unsigned SYS_RST_HOLD       = C_SYS_RST_HOLD
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam int unsigned CNT_MAX = max4(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                         LOCK_STABLE_CYCLES, SYS_RST_HOLD);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] C_LD_PLL_RST = CNT_W'(PLL_RST_CYCLES);
  localparam logic [CNT_W-1:0] C_LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] C_LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_LD_HOLD    = CNT_W'(SYS_RST_HOLD);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  logic             locked_s;
  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [7:0]       relock_q, relock_d;
  logic             tmo_q,    tmo_d;
  logic             pll_rst_q;
  logic             sys_rst_q;
  logic             lock_ok_q;
  logic             cnt_last;

  sync_2ff u_sync_locked (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  // Current cycle is the final one of whatever interval the counter was loaded with.
  assign cnt_last = (cnt_q <= C_CNT_ONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
    tmo_d    = tmo_q;

    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_last) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = C_LD_TIMEOUT;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE_CHECK;
          cnt_d   = C_LD_STABLE;
        end else if (cnt_last) begin
          state_d = ST_PLL_RESET;
          cnt_d   = C_LD_PLL_RST;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      ST_STABLE_CHECK: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = C_LD_TIMEOUT;
        end else if (cnt_last) begin
          state_d = ST_RST_HOLD;
          cnt_d   = C_LD_HOLD;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      // Lock loss is tested before expiry so it wins when both coincide.
      ST_RST_HOLD: begin
        if (!locked_s) begin
          state_d = ST_PLL_RESET;
          cnt_d   = C_LD_PLL_RST;
          if (relock_q != C_RELOCK_MAX) relock_d = relock_q + 8'd1;
        end else if (cnt_last) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RESET;
          cnt_d   = C_LD_PLL_RST;
          if (relock_q != C_RELOCK_MAX) relock_d = relock_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = C_LD_PLL_RST;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLL_RESET;
      cnt_q     <= C_LD_PLL_RST;
      relock_q  <= 8'd0;
      tmo_q     <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      tmo_q     <= tmo_d;
      pll_rst_q <= (state_d == ST_PLL_RESET);
      sys_rst_q <= (state_d != ST_RUN);
      lock_ok_q <= (state_d == ST_RUN);
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign lock_ok      = lock_ok_q;
  assign relock_count = relock_q;
  assign timeout_err  = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// +----------------------------------------------------------------------------+
// | tb_pll_lock_supervisor : directed and randomized bench with reference model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pll_lock_supervisor;

  localparam int P_RST  = 4;
  localparam int P_TMO  = 20;
  localparam int P_STB  = 8;
  localparam int P_HOLD = 4;

  localparam int PH_RESET  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_HOLD   = 3;
  localparam int PH_RUN    = 4;

  localparam int SEL_PLL = 0;
  localparam int SEL_SYS = 1;
  localparam int SEL_OK  = 2;
  localparam int SEL_TMO = 3;

  logic       refclk = 1'b0;
  logic       rst    = 1'b0;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_ok;
  logic [7:0] relock_count;
  logic       timeout_err;

  int n_total = 0;
  int n_bad   = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES     (P_RST),
    .LOCK_TIMEOUT       (P_TMO),
    .LOCK_STABLE_CYCLES (P_STB),
    .SYS_RST_HOLD       (P_HOLD)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .lock_ok      (lock_ok),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase plus elapsed-time-in-phase, locked seen two edges late.
  int       m_phase;
  int       m_age;
  int       m_relock;
  bit       m_tmo;
  bit [1:0] m_hist;
  bit       m_ls;

  task automatic m_lose();
    m_phase  = PH_RESET;
    m_age    = 0;
    m_relock = (m_relock < 255) ? m_relock + 1 : 255;
  endtask

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase = PH_RESET; m_age = 0; m_relock = 0; m_tmo = 0; m_hist = 2'b00;
    end else begin
      m_ls   = m_hist[1];
      m_hist = {m_hist[0], locked};
      case (m_phase)
        PH_RESET: begin
          m_age++;
          if (m_age == P_RST) begin m_phase = PH_WAIT; m_age = 0; end
        end
        PH_WAIT: begin
          if (m_ls) begin m_phase = PH_STABLE; m_age = 0; end
          else begin
            m_age++;
            if (m_age == P_TMO) begin m_tmo = 1; m_phase = PH_RESET; m_age = 0; end
          end
        end
        PH_STABLE: begin
          if (!m_ls) begin m_phase = PH_WAIT; m_age = 0; end
          else begin
            m_age++;
            if (m_age == P_STB) begin m_phase = PH_HOLD; m_age = 0; end
          end
        end
        PH_HOLD: begin
          if (!m_ls) m_lose();
          else begin
            m_age++;
            if (m_age == P_HOLD) begin m_phase = PH_RUN; m_age = 0; end
          end
        end
        default: if (!m_ls) m_lose();
      endcase
    end
  end

  always @(negedge refclk) begin
    chk("mdl_pll_rst", pll_rst,      m_phase == PH_RESET);
    chk("mdl_sys_rst", sys_rst,      m_phase != PH_RUN);
    chk("mdl_lock_ok", lock_ok,      m_phase == PH_RUN);
    chk("mdl_relock",  relock_count, m_relock);
    chk("mdl_tmo",     timeout_err,  m_tmo);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge refclk); #2 rst = 1'b1;
    repeat (3) @(negedge refclk);
    #2 rst = 1'b0;
  endtask

  // Counts rising edges until the selected output equals val; returns bound+1 on expiry.
  task automatic edges_until(input int sel, input logic val, input int bound, output int n);
    logic v;
    n = 0;
    do begin
      @(posedge refclk); #1;
      n++;
      case (sel)
        SEL_PLL: v = pll_rst;
        SEL_SYS: v = sys_rst;
        SEL_OK:  v = lock_ok;
        default: v = timeout_err;
      endcase
    end while (v !== val && n <= bound);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  seen_low;

    #1 rst = 1'b1;
    cyc(3);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_lock_ok", lock_ok, 0);
    chk("rst_relock",  relock_count, 0);
    chk("rst_tmo",     timeout_err, 0);

    // Normal bring-up
    rst = 1'b0;
    edges_until(SEL_PLL, 1'b0, 50, n);
    chk("bringup_pll_rst_width", n, P_RST);
    repeat (10 - P_RST) @(posedge refclk);
    @(negedge refclk); #2 locked = 1'b1;
    edges_until(SEL_OK, 1'b1, 100, n);
    chk("bringup_lock_latency", n, 2 + 1 + P_STB + P_HOLD);
    chk("bringup_sys_rst", sys_rst, 0);

    // Short lock glitch while waiting
    locked = 1'b0;
    do_reset();
    cyc(8);
    locked = 1'b1;
    cyc(3);
    locked = 1'b0;
    seen_low = 1'b0;
    repeat (30) begin
      @(posedge refclk); #1;
      if (!sys_rst || lock_ok) seen_low = 1'b1;
    end
    chk("glitch_sys_rst_held", seen_low, 0);
    chk("glitch_relock", relock_count, 0);

    // Lock timeout and repeating PLL reset pulses
    do_reset();
    edges_until(SEL_TMO, 1'b1, 100, n);
    chk("tmo_latency", n, P_RST + P_TMO);
    chk("tmo_pll_rst_reasserted", pll_rst, 1);
    edges_until(SEL_PLL, 1'b0, 50, n);
    chk("tmo_pulse_width", n, P_RST);
    edges_until(SEL_PLL, 1'b1, 100, n);
    chk("tmo_repeat_period", n, P_TMO);
    edges_until(SEL_PLL, 1'b0, 50, n);
    chk("tmo_pulse_width2", n, P_RST);
    chk("tmo_sticky", timeout_err, 1);

    // Lock loss in RUN
    @(negedge refclk); #2 locked = 1'b1;
    edges_until(SEL_OK, 1'b1, 100, n);
    chk("run_reached", lock_ok, 1);
    @(negedge refclk); #2 locked = 1'b0;
    edges_until(SEL_SYS, 1'b1, 10, n);
    chk("loss_latency", n, 3);
    chk("loss_lock_ok", lock_ok, 0);
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_relock",  relock_count, 1);
    chk("loss_tmo_kept", timeout_err, 1);

    // Randomized lock activity against the model
    cyc(1);
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      locked = 1'b1;
      cyc(int'($urandom_range(1, 40)));
      locked = 1'b0;
      cyc(($urandom_range(0, 7) == 0) ? 30 : int'($urandom_range(1, 4)));
    end

    // Saturation of relock_count
    do_reset();
    locked = 1'b1;
    for (int i = 0; i < 260; i++) begin
      edges_until(SEL_OK, 1'b1, 100, n);
      if (n > 100) begin
        chk("sat_wait_run", n, 100);
        break;
      end
      @(negedge refclk); #2 locked = 1'b0;
      @(negedge refclk); #2 locked = 1'b1;
      edges_until(SEL_OK, 1'b0, 10, n);
      if (i == 254) chk("sat_at_255", relock_count, 255);
    end
    chk("sat_final", relock_count, 255);

    // Asynchronous reset while in RUN
    edges_until(SEL_OK, 1'b1, 100, n);
    chk("pre_rst_run", lock_ok, 1);
    @(negedge refclk); #2 rst = 1'b1;
    #1;
    chk("arst_pll_rst", pll_rst, 1);
    chk("arst_sys_rst", sys_rst, 1);
    chk("arst_lock_ok", lock_ok, 0);
    chk("arst_relock",  relock_count, 0);
    chk("arst_tmo",     timeout_err, 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
